rgb_pwm_fader: RTL and testbench
================================

Name: rgb_pwm_fader

Overview:
Downstream stage of the blink/colour sequencer. It consumes a 3-bit RGB colour request and drives the three LED pins with 8-bit PWM. On each request, every channel's brightness ramps linearly toward its new target (full on or off), so steps become fades. The block sits between the colour-state generator and the RGB_R/RGB_G/RGB_B top-level pins.

Parameters:
PWM_BITS, 8, width of the duty registers and the free-running PWM counter
FADE_INTERVAL, 46875, clk cycles per fade tick (12 MHz / 46875 = 256 ticks/s)
FADE_STEP, 1, duty increment/decrement applied per fade tick (must be ≥1)
LED_ACTIVE_LOW, 0, 1 = pins driven low when lit

Ports:
clk  in  1  system clock (12 MHz)
rst  in  1  synchronous reset, active-high
color_valid  in  1  colour request strobe
color  in  3  {R,G,B} target; bit=1 → channel target duty 2^PWM_BITS-1, bit=0 → 0
color_ready  out  1  always 1 outside reset; request accepted when color_valid high
busy  out  1  high while any channel duty ≠ its target
done  out  1  one-cycle pulse when the last channel reaches its target
RGB_R  out  1  red LED pin
RGB_G  out  1  green LED pin
RGB_B  out  1  blue LED pin

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst sampled high at posedge): pwm_cnt=0, fade_cnt=0, all duties=0, all targets=0, state=IDLE, busy=0, done=0, color_ready=0 during reset, and pins at inactive level (0, or 1 if LED_ACTIVE_LOW). Reset mid-fade aborts immediately with no done pulse.
- PWM: pwm_cnt increments every cycle and wraps from 2^PWM_BITS-1 to 0. Channel lit iff duty > pwm_cnt (registered output, 1-cycle latency). duty=0 → never lit. duty=255 → lit 255 of 256 cycles. All channels share pwm_cnt.
- Request: on color_valid at a posedge, targets load from color the next cycle. fade_cnt clears to 0 and state=FADING, unless every target already equals its duty, in which case the block stays IDLE with no done pulse.
- Fade tick: in FADING, fade_cnt counts 0..FADE_INTERVAL-1. The tick fires on the cycle fade_cnt=FADE_INTERVAL-1, then wraps. On a tick each duty moves toward its target by FADE_STEP, saturating exactly at target with no overshoot. This includes the case where FADE_STEP does not divide 255.
- FSM:
  - IDLE → FADING on an accepted request with any mismatch.
  - FADING → IDLE on the tick where all duties reach their targets; done=1 for exactly that next cycle.
  - In IDLE, fade_cnt holds at 0.
- busy = (state==FADING).
- Retarget mid-fade: a new request in FADING replaces the targets, keeps the current duties (fade reverses from the present brightness), and restarts fade_cnt at 0. No done pulse for the abandoned fade.
- Simultaneous request and final tick: the tick is applied first, then the new targets load. If a mismatch remains, the block stays FADING and done is suppressed.
- Full fade 0→255 at defaults: 255 ticks ≈ 0.996 s.
- Arithmetic: duty update is computed in PWM_BITS+1 bits and clamped to target. No wrap-around is allowed.

Decomposition:
- Package rgb_pkg holds:
  - typedef struct packed {r,g,b} color_t
  - typedef logic [PWM_BITS-1:0] duty_t
  - enum {IDLE, FADING} fade_state_t
  - localparam DUTY_MAX
- Sub-module rgb_pwm_channel, instantiated ×3. Inputs: clk, rst, tick, target_on, shared pwm_cnt. Outputs: duty_eq_target, pin_raw. It contains the duty register, saturating step logic and comparator.
- Top-level rgb_pwm_fader contains pwm_cnt, fade_cnt, the FSM, done/busy and polarity inversion.

Test Plan (override FADE_INTERVAL=4, FADE_STEP=64 unless noted):
- Reset then idle 600 cycles → all pins 0, busy=0, done never pulses, color_ready=1 after rst deasserts.
- color=3'b100 for one cycle → R duty steps 0,64,128,192,255 every 4 cycles. Exactly one done pulse, 1 cycle after the 4th tick. In the steady state RGB_R is high 255 of every 256 cycles and G/B stay 0.
- During the ramp above at R duty=128, send color=3'b001 → R falls 128→64→0 while B rises 0→64→128. A single done pulse occurs when both settle, and no done is emitted for the abandoned fade.
- Request the same colour while IDLE at target → state stays IDLE, no busy, no done. Then assert rst mid-fade with R duty=64 → the next cycle has duty 0, pins 0, busy=0 and no done.
- Request on the exact cycle of the final tick → busy stays 1, no done, and the new fade proceeds.
- LED_ACTIVE_LOW=1, FADE_STEP=1 → reset pins are 1. A 0→255 fade takes 255 ticks, ends exactly at 255 with no overshoot, and the inverted duty cycle is checked at duty=100 (pin low for 100 of 256 cycles).

Source files
------------

// File: rtl/rgb_pwm_fader_pkg.sv
// Shared types and constants for the RGB PWM fader: colour request layout,
// duty word type and fade FSM encoding.
package rgb_pkg;

    localparam int PWM_W = 8;

    typedef logic [PWM_W-1:0] duty_t;

    localparam duty_t DUTY_MAX = '1;

    // Bit order matches the request word {R,G,B}.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } color_t;

    typedef enum logic {
        IDLE   = 1'b0,
        FADING = 1'b1
    } fade_state_t;

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Colour request and status bundle between the colour-state generator
// (master) and the fader (slave).
interface rgb_pwm_fader_if;

    // A request transfers on any posedge where color_valid && color_ready;
    // color_ready is high whenever the fader is out of reset, so there is no
    // back-pressure, and color must be stable while color_valid is high.
    logic            color_valid;
    rgb_pkg::color_t color;
    logic            color_ready;
    logic            busy;
    logic            done;

    modport master (
        output color_valid,
        output color,
        input  color_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  color_valid,
        input  color,
        output color_ready,
        output busy,
        output done
    );

endinterface

// File: rtl/rgb_pwm_channel.sv
// One LED channel: duty register with saturating fade step toward full-on or
// off, plus the registered PWM comparator against the shared counter.
module rgb_pwm_channel #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                target_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] duty,
    output logic [PWM_BITS-1:0] duty_next,
    output logic                duty_eq_target,
    output logic                pin_raw
);

    localparam logic [PWM_BITS:0]   STEP     = (PWM_BITS + 1)'(FADE_STEP);
    localparam logic [PWM_BITS:0]   MAX_WIDE = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS-1:0] ON_LEVEL = '1;

    logic [PWM_BITS:0] duty_wide;
    logic [PWM_BITS:0] up_sum;
    logic [PWM_BITS:0] stepped;

    // One extra bit of headroom so the add cannot wrap before the clamp.
    always_comb begin
        duty_wide = {1'b0, duty};
        up_sum    = duty_wide + STEP;
        stepped   = '0;
        if (target_on) begin
            stepped = (up_sum > MAX_WIDE) ? MAX_WIDE : up_sum;
        end else begin
            stepped = (duty_wide > STEP) ? (duty_wide - STEP) : '0;
        end
        duty_next = tick ? stepped[PWM_BITS-1:0] : duty;
    end

    // Compared against the post-update value so the FSM sees settling on the
    // same cycle as the final tick.
    assign duty_eq_target = (duty_next == (target_on ? ON_LEVEL : '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            duty    <= '0;
            pin_raw <= 1'b0;
        end else begin
            duty    <= duty_next;
            pin_raw <= (duty > pwm_cnt);
        end
    end

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM fader top: shared PWM and fade-tick counters, fade FSM, request
// handling and pin polarity, around three rgb_pwm_channel instances.
module rgb_pwm_fader
    import rgb_pkg::*;
#(
    parameter int PWM_BITS       = PWM_W,
    parameter int FADE_INTERVAL  = 46875,
    parameter int FADE_STEP      = 1,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    rgb_pwm_fader_if.slave      bus,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B,
    output fade_state_t         fsm_state,
    output logic [PWM_BITS-1:0] duty_r,
    output logic [PWM_BITS-1:0] duty_g,
    output logic [PWM_BITS-1:0] duty_b
);

    localparam int              FC_W      = $clog2(FADE_INTERVAL + 1);
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FADE_INTERVAL - 1);
    localparam logic            PIN_INVERT = (LED_ACTIVE_LOW != 0);

    fade_state_t         state, state_next;
    logic [FC_W-1:0]     fade_cnt, fade_cnt_next;
    logic [PWM_BITS-1:0] pwm_cnt;
    color_t              target, target_next;
    logic                done_q, done_next;
    logic                tick, accept, all_eq, new_mismatch;
    logic [PWM_BITS-1:0] dn_r, dn_g, dn_b;
    logic                eq_r, eq_g, eq_b;
    logic                raw_r, raw_g, raw_b;

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_chan_r (
        .clk(clk), .rst(rst), .tick(tick), .target_on(target.r), .pwm_cnt(pwm_cnt),
        .duty(duty_r), .duty_next(dn_r), .duty_eq_target(eq_r), .pin_raw(raw_r)
    );
    rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_chan_g (
        .clk(clk), .rst(rst), .tick(tick), .target_on(target.g), .pwm_cnt(pwm_cnt),
        .duty(duty_g), .duty_next(dn_g), .duty_eq_target(eq_g), .pin_raw(raw_g)
    );
    rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_chan_b (
        .clk(clk), .rst(rst), .tick(tick), .target_on(target.b), .pwm_cnt(pwm_cnt),
        .duty(duty_b), .duty_next(dn_b), .duty_eq_target(eq_b), .pin_raw(raw_b)
    );

    assign tick   = (state == FADING) && (fade_cnt == FC_LAST);
    assign accept = bus.color_valid && bus.color_ready;
    assign all_eq = eq_r && eq_g && eq_b;

    // A new request is judged against the duties after this cycle's tick.
    assign new_mismatch = (dn_r != {PWM_BITS{bus.color.r}}) ||
                          (dn_g != {PWM_BITS{bus.color.g}}) ||
                          (dn_b != {PWM_BITS{bus.color.b}});

    always_comb begin
        state_next    = state;
        fade_cnt_next = fade_cnt;
        target_next   = target;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                fade_cnt_next = '0;
            end
            FADING: begin
                fade_cnt_next = tick ? '0 : fade_cnt + FC_W'(1);
                if (tick && all_eq) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                fade_cnt_next = '0;
            end
        endcase
        if (accept) begin
            target_next   = bus.color;
            fade_cnt_next = '0;
            state_next    = new_mismatch ? FADING : IDLE;
            done_next     = tick && all_eq && !new_mismatch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fade_cnt <= '0;
            target   <= '0;
            done_q   <= 1'b0;
            pwm_cnt  <= '0;
        end else begin
            state    <= state_next;
            fade_cnt <= fade_cnt_next;
            target   <= target_next;
            done_q   <= done_next;
            pwm_cnt  <= pwm_cnt + 1'b1;
        end
    end

    assign bus.color_ready = ~rst;
    assign bus.busy        = (state == FADING);
    assign bus.done        = done_q;
    assign fsm_state       = state;

    assign RGB_R = raw_r ^ PIN_INVERT;
    assign RGB_G = raw_g ^ PIN_INVERT;
    assign RGB_B = raw_b ^ PIN_INVERT;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: fast-fade instance plus two active-low
// instances for fine-step and held-duty checks.
module tb_rgb_pwm_fader;
    import rgb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_pwm_fader_if bus1();
    rgb_pwm_fader_if bus2();
    rgb_pwm_fader_if bus3();

    logic        r1, g1, b1, r2, g2, b2, r3, g3, b3;
    fade_state_t st1, st2, st3;
    duty_t       dr1, dg1, db1, dr2, dg2, db2, dr3, dg3, db3;

    rgb_pwm_fader #(.FADE_INTERVAL(4), .FADE_STEP(64), .LED_ACTIVE_LOW(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .RGB_R(r1), .RGB_G(g1), .RGB_B(b1),
        .fsm_state(st1), .duty_r(dr1), .duty_g(dg1), .duty_b(db1)
    );
    rgb_pwm_fader #(.FADE_INTERVAL(4), .FADE_STEP(1), .LED_ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .RGB_R(r2), .RGB_G(g2), .RGB_B(b2),
        .fsm_state(st2), .duty_r(dr2), .duty_g(dg2), .duty_b(db2)
    );
    rgb_pwm_fader #(.FADE_INTERVAL(300), .FADE_STEP(100), .LED_ACTIVE_LOW(1)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .RGB_R(r3), .RGB_G(g3), .RGB_B(b3),
        .fsm_state(st3), .duty_r(dr3), .duty_g(dg3), .duty_b(db3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int log_r[0:31], log_g[0:31], log_b[0:31], log_done[0:31], log_busy[0:31];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_log(input int n);
        for (int k = 1; k <= n; k++) begin
            step(1);
            log_r[k]    = int'(dr1);
            log_g[k]    = int'(dg1);
            log_b[k]    = int'(db1);
            log_done[k] = int'(bus1.done);
            log_busy[k] = int'(bus1.busy);
        end
    endtask

    task automatic send1(input logic [2:0] c);
        bus1.color_valid = 1'b1;
        bus1.color       = c;
        step(1);
        bus1.color_valid = 1'b0;
    endtask

    function automatic int exp_up(input int k, input int st, input int iv);
        int v;
        v = (k / iv) * st;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int exp_dn(input int s, input int k, input int st, input int iv);
        int v;
        v = s - (k / iv) * st;
        return (v < 0) ? 0 : v;
    endfunction

    initial begin
        int cnt_a, cnt_b, cnt_c, cnt_d;
        bus1.color_valid = 1'b0; bus1.color = '0;
        bus2.color_valid = 1'b0; bus2.color = '0;
        bus3.color_valid = 1'b0; bus3.color = '0;

        // Reset state
        step(3);
        check_eq("rst_ready", bus1.color_ready, 0);
        check_eq("rst_busy", bus1.busy, 0);
        check_eq("rst_done", bus1.done, 0);
        check_eq("rst_pins_hi_pol", {r1, g1, b1}, 3'b000);
        check_eq("rst_pins_lo_pol", {r2, g2, b2, r3, g3, b3}, 6'b111111);
        check_eq("rst_state", st1, IDLE);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", bus1.color_ready, 1);

        // Idle 600 cycles
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int k = 0; k < 600; k++) begin
            step(1);
            cnt_a += int'(r1) + int'(g1) + int'(b1);
            cnt_b += int'(bus1.busy);
            cnt_c += int'(bus1.done);
            cnt_d += 6 - (int'(r2) + int'(g2) + int'(b2) + int'(r3) + int'(g3) + int'(b3));
        end
        check_eq("idle_pins_lit", cnt_a, 0);
        check_eq("idle_busy", cnt_b, 0);
        check_eq("idle_done", cnt_c, 0);
        check_eq("idle_lo_pol_lit", cnt_d, 0);

        // Red ramp 0 -> 255
        send1(3'b100);
        check_eq("ramp_busy_start", bus1.busy, 1);
        run_log(17);
        cnt_c = 0;
        for (int k = 1; k <= 17; k++) begin
            check_eq($sformatf("ramp_r_k%0d", k), log_r[k], exp_up(k, 64, 4));
            cnt_c += log_done[k];
        end
        check_eq("ramp_done_count", cnt_c, 1);
        check_eq("ramp_done_k16", log_done[16], 1);
        check_eq("ramp_busy_k15", log_busy[15], 1);
        check_eq("ramp_busy_k16", log_busy[16], 0);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 256; k++) begin
            step(1);
            cnt_a += int'(r1);
            cnt_b += int'(g1) + int'(b1);
        end
        check_eq("steady_r_high", cnt_a, 255);
        check_eq("steady_gb_high", cnt_b, 0);

        // Retarget mid-fade at R=128
        rst = 1'b1; step(1); rst = 1'b0;
        send1(3'b100);
        run_log(8);
        check_eq("retgt_r_before", log_r[8], 128);
        cnt_c = 0;
        for (int k = 1; k <= 8; k++) cnt_c += log_done[k];
        send1(3'b001);
        run_log(20);
        for (int k = 1; k <= 20; k++) begin
            check_eq($sformatf("retgt_r_k%0d", k), log_r[k], exp_dn(128, k, 64, 4));
            check_eq($sformatf("retgt_b_k%0d", k), log_b[k], exp_up(k, 64, 4));
            cnt_c += log_done[k];
        end
        check_eq("retgt_done_count", cnt_c, 1);
        check_eq("retgt_done_k16", log_done[16], 1);

        // Same colour while idle at target
        send1(3'b001);
        check_eq("same_state", st1, IDLE);
        run_log(8);
        cnt_b = 0; cnt_c = 0;
        for (int k = 1; k <= 8; k++) begin
            cnt_b += log_busy[k];
            cnt_c += log_done[k];
        end
        check_eq("same_busy", cnt_b, 0);
        check_eq("same_done", cnt_c, 0);

        // Reset mid-fade at R=64
        send1(3'b100);
        run_log(4);
        check_eq("midrst_r_before", log_r[4], 64);
        check_eq("midrst_b_before", log_b[4], 191);
        rst = 1'b1;
        step(1);
        check_eq("midrst_duty", {dr1, dg1, db1}, 24'h000000);
        check_eq("midrst_pins", {r1, g1, b1}, 3'b000);
        check_eq("midrst_busy", bus1.busy, 0);
        check_eq("midrst_done", bus1.done, 0);
        check_eq("midrst_ready", bus1.color_ready, 0);
        rst = 1'b0;
        run_log(8);
        cnt_c = 0;
        for (int k = 1; k <= 8; k++) cnt_c += log_done[k];
        check_eq("midrst_done_after", cnt_c, 0);

        // Request on the final tick
        send1(3'b100);
        run_log(15);
        cnt_c = 0;
        for (int k = 1; k <= 15; k++) cnt_c += log_done[k];
        send1(3'b010);
        check_eq("ftick_busy", bus1.busy, 1);
        check_eq("ftick_done", bus1.done, 0);
        check_eq("ftick_r", dr1, 255);
        check_eq("ftick_g", dg1, 0);
        run_log(20);
        for (int k = 1; k <= 20; k++) begin
            check_eq($sformatf("ftick_r_k%0d", k), log_r[k], exp_dn(255, k, 64, 4));
            check_eq($sformatf("ftick_g_k%0d", k), log_g[k], exp_up(k, 64, 4));
            cnt_c += log_done[k];
        end
        check_eq("ftick_done_count", cnt_c, 1);
        check_eq("ftick_done_k16", log_done[16], 1);

        // Active-low instances: fine-step full fade and held duty of 100
        bus2.color_valid = 1'b1; bus2.color = 3'b100;
        bus3.color_valid = 1'b1; bus3.color = 3'b100;
        step(1);
        bus2.color_valid = 1'b0;
        bus3.color_valid = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 1; k <= 1030; k++) begin
            step(1);
            cnt_a += int'(bus2.done);
            cnt_b += int'(bus3.done);
            if (k >= 302 && k <= 557) cnt_c += int'(!r3);
            if (k == 4)    check_eq("fine_r_k4", dr2, 1);
            if (k == 400)  check_eq("fine_r_k400", dr2, 100);
            if (k == 1019) check_eq("fine_r_k1019", dr2, 254);
            if (k == 1019) check_eq("fine_busy_k1019", bus2.busy, 1);
            if (k == 1020) check_eq("fine_r_k1020", dr2, 255);
            if (k == 1020) check_eq("fine_done_k1020", bus2.done, 1);
            if (k == 300)  check_eq("held_r_k300", dr3, 100);
            if (k == 600)  check_eq("held_r_k600", dr3, 200);
            if (k == 900)  check_eq("held_r_k900", dr3, 255);
            if (k == 900)  check_eq("held_done_k900", bus3.done, 1);
        end
        check_eq("fine_r_final", dr2, 255);
        check_eq("fine_busy_final", bus2.busy, 0);
        check_eq("fine_done_count", cnt_a, 1);
        check_eq("fine_gb_pins", {g2, b2}, 2'b11);
        check_eq("held_pin_low_count", cnt_c, 100);
        check_eq("held_done_count", cnt_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
